// File: rtl/al_accel_odr_drain_pkg.sv
// Shared sizing, FSM encoding and word-index helpers for the ODR drain block.
// Optional requantization is enabled by defining AL_ACCEL_ODR_REQUANT_EN.
package al_accel_odr_drain_pkg;

    localparam int unsigned NPU   = 3;
    localparam int unsigned NLANE = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned NW    = NPU * NLANE;
    localparam int unsigned IW    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic logic [IW-1:0] word_idx(input int unsigned row, input int unsigned lane);
        return IW'(row * NLANE + lane);
    endfunction

    // {found, k}: lowest k >= start whose row is enabled in mask
    function automatic logic [IW:0] next_en(input logic [NPU-1:0] mask, input logic [IW-1:0] start);
        logic [IW:0] res;
        res = '0;
        for (int r = int'(NPU) - 1; r >= 0; r--) begin
            for (int l = int'(NLANE) - 1; l >= 0; l--) begin
                if (mask[r] && (word_idx(r, l) >= start)) begin
                    res = {1'b1, word_idx(r, l)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/al_accel_odr_requant.sv
// Combinational int8 requantization of one result word:
// (x * mult) >>> shift, low 32 bits plus offset, clamped to [act_min, act_max].
module al_accel_odr_requant
    import al_accel_odr_drain_pkg::*;
(
    input  logic [DW-1:0] x_i,
    input  logic [31:0]   mult_i,
    input  logic [5:0]    shift_i,
    input  logic [31:0]   offset_i,
    input  logic [7:0]    act_min_i,
    input  logic [7:0]    act_max_i,
    output logic [DW-1:0] y_o
);

    logic signed [63:0] xs_c;
    logic signed [63:0] ms_c;
    logic signed [63:0] prod_c;
    logic        [31:0] sum_c;
    logic        [31:0] min_c;
    logic        [31:0] max_c;
    logic        [7:0]  clamp_c;

    always_comb begin
        xs_c    = {{32{x_i[31]}}, x_i};
        ms_c    = {{32{mult_i[31]}}, mult_i};
        prod_c  = xs_c * ms_c;
        sum_c   = 32'(prod_c >>> shift_i) + offset_i;
        min_c   = {{24{act_min_i[7]}}, act_min_i};
        max_c   = {{24{act_max_i[7]}}, act_max_i};
        clamp_c = sum_c[7:0];
        if ($signed(sum_c) < $signed(min_c)) begin
            clamp_c = act_min_i;
        end else if ($signed(sum_c) > $signed(max_c)) begin
            clamp_c = act_max_i;
        end
        y_o = {{24{clamp_c[7]}}, clamp_c};
    end

endmodule

// File: rtl/al_accel_odr_drain.sv
// Captures the PU array's nine partial sums and drains enabled rows over a valid/ready stream.
// Define AL_ACCEL_ODR_REQUANT_EN to requantize each word to int8 on the way out.
module al_accel_odr_drain
    import al_accel_odr_drain_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NW*DW-1:0]   odr_odi,
    input  logic               odr_cap,
    input  logic [NPU-1:0]     odr_row_mask,
    output logic [DW-1:0]      odr_do,
    output logic [IW-1:0]      odr_do_idx,
    output logic               odr_do_valid,
    input  logic               odr_do_ready,
    output logic               odr_do_last,
    output logic               odr_busy,
    output logic               odr_done,
    output logic               odr_ovf,
    input  logic               odr_ovf_clr,
    input  logic [31:0]        odr_out_offset,
    input  logic [31:0]        odr_mult,
    input  logic [5:0]         odr_shift,
    input  logic [7:0]         odr_act_min,
    input  logic [7:0]         odr_act_max
);

    state_e          state_q, state_d;
    logic [DW-1:0]   buf_q [NW];
    logic [NPU-1:0]  mask_q;
    logic [DW-1:0]   do_q, do_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            busy_q;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic            xfer_c, fin_c, accept_c, drop_c, mask_nz_c, load_c;
    logic [IW:0]     first_c, first_nxt_c, adv_c, adv_nxt_c;
    logic [DW-1:0]   raw_c, word_c;

    assign xfer_c      = valid_q & odr_do_ready;
    assign fin_c       = xfer_c & last_q;
    assign accept_c    = odr_cap & ((state_q == ST_IDLE) | fin_c);
    assign drop_c      = odr_cap & ~accept_c;
    assign mask_nz_c   = |odr_row_mask;
    assign first_c     = next_en(odr_row_mask, '0);
    assign first_nxt_c = next_en(odr_row_mask, IW'(first_c[IW-1:0] + 4'd1));
    assign adv_c       = next_en(mask_q, IW'(idx_q + 4'd1));
    assign adv_nxt_c   = next_en(mask_q, IW'(adv_c[IW-1:0] + 4'd1));

`ifdef AL_ACCEL_ODR_REQUANT_EN
    al_accel_odr_requant u_requant (
        .x_i       (raw_c),
        .mult_i    (odr_mult),
        .shift_i   (odr_shift),
        .offset_i  (odr_out_offset),
        .act_min_i (odr_act_min),
        .act_max_i (odr_act_max),
        .y_o       (word_c)
    );
`else
    logic unused_requant;
    assign unused_requant = ^{odr_out_offset, odr_mult, odr_shift, odr_act_min, odr_act_max};
    assign word_c = raw_c;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c && mask_nz_c) state_d = ST_DRAIN;
            ST_DRAIN: if (fin_c) state_d = (accept_c && mask_nz_c) ? ST_DRAIN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stream register next values: new capture, final handshake, or advance to next enabled word
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        load_c  = 1'b0;
        raw_c   = buf_q[idx_q];
        done_d  = fin_c | (accept_c & ~mask_nz_c);
        ovf_d   = drop_c | (ovf_q & ~odr_ovf_clr);
        if (accept_c) begin
            valid_d = mask_nz_c;
            last_d  = mask_nz_c & ~first_nxt_c[IW];
            idx_d   = first_c[IW-1:0];
            raw_c   = odr_odi[32'(first_c[IW-1:0]) * DW +: DW];
            load_c  = mask_nz_c;
        end else if (fin_c) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (xfer_c) begin
            idx_d   = adv_c[IW-1:0];
            last_d  = ~adv_nxt_c[IW];
            raw_c   = buf_q[adv_c[IW-1:0]];
            load_c  = 1'b1;
        end
        do_d = load_c ? word_c : do_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(NW); k++) buf_q[k] <= '0;
            mask_q  <= '0;
            do_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                for (int k = 0; k < int'(NW); k++) buf_q[k] <= odr_odi[k*DW +: DW];
                mask_q <= odr_row_mask;
            end
            do_q    <= do_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign odr_do       = do_q;
    assign odr_do_idx   = idx_q;
    assign odr_do_valid = valid_q;
    assign odr_do_last  = last_q;
    assign odr_busy     = busy_q;
    assign odr_done     = done_q;
    assign odr_ovf      = ovf_q;

endmodule
